// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, control states and the
// ADD/SUB signed-overflow rule.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_ULT = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Operand-sign rule: same-signed operands producing a result of the other sign.
  function automatic logic addsub_ovf(input logic a_msb, input logic b_eff_msb,
                                      input logic res_msb);
    return (a_msb == b_eff_msb) && (res_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_n_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle over WIDTH cycles.
// done/product are combinational so the caller registers the final sum on the last step.
module mul_shift_add import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic               run_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = run_q && (cnt_q == '0);
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= CNT_TOP;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q - CNT_ONE;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Registered ALU with valid/ready intake, flag registers and a multi-cycle multiply.
// Handshake: a request is taken when in_valid && in_ready at a rising clk edge; out_valid pulses once per taken request.
module alu_seq_n import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);
  state_e state_q, state_d;
  op_e    op_sel;
  logic   accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] result_q, result_d, alu_res, b_add;
  logic [WIDTH:0]   sum;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic out_valid_q, out_valid_d;
  logic alu_c, alu_v, is_sub, b_eff_msb;

  assign op_sel = op_e'(op);
  assign is_mul = (op_sel == OP_MUL);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    busy      = (state_q == S_MUL);
    mul_start = accept && is_mul;
  end

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    is_sub  = (op_sel == OP_SUB);
    b_add   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    // msb of (~b + 1): ~b's msb flipped by the carry that only all-zero low bits produce.
    b_eff_msb = is_sub ? (~b[WIDTH-1] ^ (b[WIDTH-2:0] == '0)) : b[WIDTH-1];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = addsub_ovf(a[WIDTH-1], b_eff_msb, sum[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ULT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = 1'b0;
    if (mul_done) begin
      result_d    = mul_product[WIDTH-1:0];
      carry_d     = |mul_product[2*WIDTH-1:WIDTH];
      ovf_d       = 1'b0;
      zero_d      = (mul_product[WIDTH-1:0] == '0);
      neg_d       = mul_product[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (accept && !is_mul) begin
      result_d    = alu_res;
      carry_d     = alu_c;
      ovf_d       = alu_v;
      zero_d      = (alu_res == '0);
      neg_d       = alu_res[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n: a WIDTH=4 and a WIDTH=8 instance checked against an
// arithmetic reference model, with directed corner steps and random ops.
module tb_alu_seq_n;
  logic clk = 1'b0;
  logic rst = 1'b1;

  // index 0 -> WIDTH=4 instance, index 1 -> WIDTH=8 instance
  logic       iv   [2];
  logic [2:0] op_s [2];
  logic [7:0] a_s  [2];
  logic [7:0] b_s  [2];
  logic       ir [2], ov [2], cy [2], vf [2], zf [2], nf [2], bz [2];
  logic [7:0] rs [2];
  logic [3:0] r4;
  logic [7:0] r8;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_e [2];
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .out_valid(ov[0]), .result(r4),
    .carry(cy[0]), .overflow(vf[0]), .zero(zf[0]), .negative(nf[0]), .busy(bz[0])
  );

  alu_seq_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .result(r8),
    .carry(cy[1]), .overflow(vf[1]), .zero(zf[1]), .negative(nf[1]), .busy(bz[1])
  );

  assign rs[0] = {4'b0000, r4};
  assign rs[1] = r8;

  // Reference model: returns {result[7:0], carry, overflow, zero, negative}.
  function automatic logic [11:0] model(input int w, input logic [2:0] o,
                                        input logic [7:0] x, input logic [7:0] y);
    int mask, top, ua, ub, sa, sb, r, beff;
    logic c, v;
    mask = (1 << w) - 1;
    top  = 1 << (w - 1);
    ua = int'(x) & mask;
    ub = int'(y) & mask;
    sa = (ua >= top) ? ua - (1 << w) : ua;
    sb = (ub >= top) ? ub - (1 << w) : ub;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        r = (ua + ub) & mask;
        c = (ua + ub) > mask;
        v = ((sa + sb) >= top) || ((sa + sb) < -top);
      end
      3'd1: begin
        r    = (ua - ub) & mask;
        c    = ua >= ub;
        beff = (-ub) & mask;
        v    = ((ua >= top) == (beff >= top)) && ((r >= top) != (ua >= top));
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (ua < ub) ? 1 : 0;
      default: begin
        r = (ua * ub) & mask;
        c = (ua * ub) > mask;
      end
    endcase
    return {r[7:0], c, v, (r == 0), (r >= top)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input int s, input logic [11:0] e);
    chk("result", {24'h0, rs[s]}, {24'h0, e[11:4]});
    chk("carry", {31'h0, cy[s]}, {31'h0, e[3]});
    chk("overflow", {31'h0, vf[s]}, {31'h0, e[2]});
    chk("zero", {31'h0, zf[s]}, {31'h0, e[1]});
    chk("negative", {31'h0, nf[s]}, {31'h0, e[0]});
  endtask

  // One request, wait (bounded) for out_valid, check latency and all outputs.
  task automatic do_op(input int s, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int w, lat;
    logic [11:0] e;
    w = (s == 0) ? 4 : 8;
    e = model(w, o, x, y);
    @(negedge clk);
    chk("ready_before_op", {31'h0, ir[s]}, 32'd1);
    iv[s] = 1'b1; op_s[s] = o; a_s[s] = x; b_s[s] = y;
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 1;
    while (ov[s] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (o == 3'd7) ? w + 1 : 1);
    chk_outputs(s, e);
    last_e[s] = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] bb_ops [4];
    logic [11:0] e;
    int s;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; op_s[i] = 3'd0; a_s[i] = 8'h00; b_s[i] = 8'h00;
    end

    // Reset state
    #12;
    chk("rst_ready4", {31'h0, ir[0]}, 32'd0);
    chk("rst_ready8", {31'h0, ir[1]}, 32'd0);
    chk("rst_valid", {31'h0, ov[0]}, 32'd0);
    chk_outputs(1, 12'h000);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, ir[0]}, 32'd1);

    // ADD/SUB corners at WIDTH=4
    do_op(0, 3'd0, 8'd7, 8'd1);
    do_op(0, 3'd0, 8'd15, 8'd1);
    do_op(0, 3'd1, 8'd8, 8'd8);
    do_op(0, 3'd1, 8'd3, 8'd5);

    // Reset in the middle of MUL 5*3 aborts it
    @(negedge clk);
    iv[0] = 1'b1; op_s[0] = 3'd7; a_s[0] = 8'd5; b_s[0] = 8'd3;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("mul_busy", {31'h0, bz[0]}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, bz[0]}, 32'd0);
    chk("abort_ready", {31'h0, ir[0]}, 32'd0);
    chk("abort_valid", {31'h0, ov[0]}, 32'd0);
    chk_outputs(0, 12'h000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'h0, ir[0]}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort_no_stray_valid", {31'h0, ov[0]}, 32'd0);
    end

    // Back-to-back ADD/AND/XOR/SLT at WIDTH=8
    bb_ops[0] = 3'd0; bb_ops[1] = 3'd2; bb_ops[2] = 3'd4; bb_ops[3] = 3'd5;
    for (int k = 0; k < 4; k++) exp_q.push_back(model(8, bb_ops[k], 8'h80, 8'h01));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_ready", {31'h0, ir[1]}, 32'd1);
      iv[1] = 1'b1; op_s[1] = bb_ops[k]; a_s[1] = 8'h80; b_s[1] = 8'h01;
      @(posedge clk); #1;
      chk("b2b_valid", {31'h0, ov[1]}, 32'd1);
      e = exp_q.pop_front();
      chk_outputs(1, e);
    end
    @(negedge clk); iv[1] = 1'b0;
    do_op(1, 3'd6, 8'h80, 8'h01);

    // MUL 5*3 with an ignored request while busy
    @(negedge clk);
    iv[0] = 1'b1; op_s[0] = 3'd7; a_s[0] = 8'd5; b_s[0] = 8'd3;
    @(posedge clk); #1;
    op_s[0] = 3'd0; a_s[0] = 8'd1; b_s[0] = 8'd1;
    for (int k = 0; k < 4; k++) begin
      chk("mul_busy_cycle", {31'h0, bz[0]}, 32'd1);
      chk("mul_ready_cycle", {31'h0, ir[0]}, 32'd0);
      chk("mul_valid_cycle", {31'h0, ov[0]}, 32'd0);
      if (k == 3) iv[0] = 1'b0;
      @(posedge clk); #1;
    end
    chk("mul_done_valid", {31'h0, ov[0]}, 32'd1);
    chk("mul_done_ready", {31'h0, ir[0]}, 32'd1);
    chk_outputs(0, model(4, 3'd7, 8'd5, 8'd3));
    @(posedge clk); #1;
    chk("mul_ignored_req", {31'h0, ov[0]}, 32'd0);
    do_op(0, 3'd7, 8'd5, 8'd4);
    do_op(0, 3'd7, 8'd0, 8'd9);

    // Flags hold while idle
    do_op(1, 3'd1, 8'h10, 8'h20);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, ov[1]}, 32'd0);
      chk_outputs(1, last_e[1]);
    end

    // Random operations on both widths
    for (int k = 0; k < 60; k++) begin
      s = $urandom_range(0, 1);
      do_op(s, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("idle_valid", {31'h0, ov[s]}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
Parametrised, registered successor to the team's combinational 4-bit add/subtract unit, used in board demos driven by switches/LEDs.
- Accepts one operation per valid/ready handshake and returns a registered result with carry/overflow/zero/negative flags.
- Adds logic ops, signed and unsigned compare, and a multi-cycle shift-add multiply.
- Sits between input-synchroniser logic and display/LED drivers.

Parameters:
WIDTH, 8, operand/result width in bits (legal: WIDTH >= 2)

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
op  input  3  operation code, see Behaviour
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  one-cycle pulse: result and flags updated
result  output  WIDTH  registered result
carry  output  1  carry out / no-borrow / multiply upper-half nonzero
overflow  output  1  signed overflow (ADD/SUB only)
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
busy  output  1  multiply in progress

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0; carry=0; overflow=0; zero=0; negative=0; out_valid=0; busy=0; in_ready=0 while rst held, 1 after release.
- Reset mid-multiply aborts the operation; no out_valid is produced for it.
- Accept condition: in_valid && in_ready on a rising clk edge. a, b, op are captured only on accept.
- Opcodes:
  - 0 ADD: a+b. carry = bit WIDTH of the sum.
  - 1 SUB: a + ~b + 1. carry = 1 means no borrow, so a>=b unsigned.
  - ADD/SUB overflow = operand-sign rule on a and the effective b (b or ~b+1 for SUB): (a_msb == b_eff_msb) && (result_msb != a_msb).
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0, overflow=0.
  - 5 SLT: result = 1 if signed a < signed b, else 0.
  - 6 ULT: result = 1 if unsigned a < unsigned b, else 0.
  - SLT/ULT: carry=0, overflow=0.
  - 7 MUL: result = low WIDTH bits of unsigned a*b; carry = 1 if the upper WIDTH bits are nonzero; overflow=0.
- zero and negative are always derived from the new result. All flags update together with result, only on an out_valid cycle, and otherwise hold.
- Ops 0-6: latency 1.
  - out_valid is high in the cycle after accept.
  - in_ready stays 1, so back-to-back accepts give one out_valid per cycle.
- Op 7 state machine: IDLE -> MUL on accept.
  - MUL runs a shift-add over WIDTH cycles: counter from WIDTH-1 down to 0, 2*WIDTH-bit accumulator.
  - While in MUL: in_ready=0, busy=1; in_valid is ignored (no queuing).
  - On count 0: MUL -> IDLE and the outputs are registered, so out_valid is high exactly WIDTH+1 cycles after the accept cycle.
  - in_ready returns to 1 in that same out_valid cycle.
- Wrap-around: ADD/SUB results wrap modulo 2^WIDTH.
- MUL with a or b equal to 0 still takes the full WIDTH+1 latency; no early exit.

Decomposition:
- Package alu_seq_pkg:
  - op enum (OP_ADD..OP_MUL, 3 bits)
  - state enum (S_IDLE, S_MUL)
  - function for the ADD/SUB flag computation
- Sub-module mul_shift_add, parameter WIDTH:
  - ports clk, rst, start, a, b, done, product[2*WIDTH-1:0]
  - owns the counter and accumulator
- The top level holds the handshake, op mux and flag registers.

Test Plan:
1. Reset: assert rst mid-MUL (WIDTH=4, 5*3 started) -> all outputs 0 immediately; after release, in_ready=1 and no stray out_valid.
2. WIDTH=4 ADD a=7 b=1 -> next cycle result=8, overflow=1, negative=1, carry=0, zero=0; ADD a=15 b=1 -> result=0, carry=1, zero=1, overflow=0.
3. WIDTH=4 SUB a=8 b=8 -> result=0, carry=1, zero=1; SUB a=3 b=5 -> result=14, carry=0, negative=1, overflow=0.
4. WIDTH=8 back-to-back ADD/AND/XOR/SLT (a=0x80, b=0x01) on consecutive cycles -> four consecutive out_valid pulses; SLT result=1, then ULT same operands -> 0.
5. WIDTH=4 MUL 5*3 -> in_ready=0 and busy=1 for 4 cycles, out_valid at accept+5, result=15, carry=0; a new in_valid during MUL is ignored; then MUL 5*4 -> result=4, carry=1.
6. Flag hold: after out_valid, drive in_valid=0 for 10 cycles -> result and flags are unchanged and out_valid stays 0.
